del_sync_sink: RTL and testbench



---
 rtl/fasater_hs_defs.sv | 6 +
 rtl/hs_sync.sv | 17 +
 rtl/del_sync_sink.sv | 54 +++++
 tb/tb_del_sync_sink.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fasater_hs_defs.sv
// fasater_hs_defs: shared 2-phase handshake constants and sink FSM states
package fasater_hs_defs;
    localparam logic PHASE_RST = 1'b0;
    localparam int SYNC_STAGES_DEF = 2;
    typedef enum logic [1:0] {IDLE = 2'd0, STALL = 2'd1, WAIT = 2'd2} hs_state_e;
endpackage

// File: rtl/hs_sync.sv
// hs_sync: multi-flop synchronizer for a 2-phase handshake signal
module hs_sync
    import fasater_hs_defs::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ff <= {STAGES{PHASE_RST}};
        else ff <= {ff[STAGES-2:0], d};
    assign q = ff[STAGES-1];
endmodule

// File: rtl/del_sync_sink.sv
// del_sync_sink: 2-phase bundled-data receiver into a FWFT FIFO with valid/ready output
module del_sync_sink
    import fasater_hs_defs::*;
#(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_R,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     out_A,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    hs_state_e state, state_nxt;
    logic req_s, pending, full, cap, pop;
    logic [AW:0] wr_ptr, rd_ptr, rd_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    hs_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(in_R), .q(req_s));
    assign pending = req_s ^ out_A;
    assign level   = wr_ptr - rd_ptr;
    assign full    = level == FULL_LVL;
    assign pop     = m_valid && m_ready;
    assign rd_nxt  = rd_ptr + (AW+1)'(pop);
    always_comb begin
        cap       = ((state == IDLE && pending) || state == STALL) && !full;
        state_nxt = cap ? WAIT : (state == STALL || (state == IDLE && pending)) ? STALL : IDLE;
    end
    // Output stage looks at the pre-edge write pointer, so a new word appears one edge after capture
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            out_A   <= PHASE_RST;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
        end else begin
            state   <= state_nxt;
            out_A   <= out_A ^ cap;
            wr_ptr  <= wr_ptr + (AW+1)'(cap);
            rd_ptr  <= rd_nxt;
            m_valid <= wr_ptr != rd_nxt;
            m_data  <= mem[rd_nxt[AW-1:0]];
        end
    always_ff @(posedge clk)
        if (cap) mem[wr_ptr[AW-1:0]] <= in_data;
endmodule

// File: tb/tb_del_sync_sink.sv
// tb_del_sync_sink: randomized async-agent + scoreboard bench for del_sync_sink
module tb_del_sync_sink;
    import fasater_hs_defs::*;
    localparam int DW = 32, SS = 2, DEP = 4, AW = $clog2(DEP);
    logic clk, rst_n, in_R, out_A, m_valid, m_ready;
    logic [DW-1:0] in_data, m_data;
    logic [AW:0] level;
    int passed = 0, total = 0, tog = 0, pops = 0, lvl_bad = 0;
    logic last_a = 1'b0;
    logic [DW-1:0] expq[$];
    bit sdone;

    del_sync_sink #(.DATA_W(DW), .SYNC_STAGES(SS), .DEPTH(DEP)) dut (
        .clk(clk), .rst_n(rst_n), .in_R(in_R), .in_data(in_data), .out_A(out_A),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .level(level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    // async side: waits for the previous acknowledge, then issues one transition per word
    task automatic send(input logic [31:0] w, input int gap);
        int n = 0;
        while (in_R !== out_A && n < 400) begin @(negedge clk); n++; end
        if (n == 400) check("ack_timeout", 1, 0);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_data = w;
        in_R = ~in_R;
        expq.push_back(w);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_R = 1'b0; m_ready = 1'b0; in_data = '0;
        expq.delete();
        repeat (2) @(negedge clk);
        tog = 0; pops = 0; lvl_bad = 0;
        rst_n = 1'b1;
    endtask

    task automatic drain_check(input string tag, input int n);
        m_ready = 1'b1;
        repeat (30) @(negedge clk);
        check({tag, "_empty"}, expq.size(), 0);
        check({tag, "_pops"}, pops, n);
        check({tag, "_acks"}, tog, n);
        check({tag, "_level"}, lvl_bad, 0);
    endtask

    // monitor: scoreboard pops and track occupancy as acknowledged words minus popped words
    always @(negedge clk) begin
        #1;
        if (!rst_n) last_a = out_A;
        else begin
            if (out_A !== last_a) tog++;
            last_a = out_A;
            if (int'(level) != tog - pops) lvl_bad++;
            if (m_valid && m_ready) begin
                if (expq.size() == 0) check("spurious_pop", 1, 0);
                else check("pop_data", m_data, expq.pop_front());
                pops++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, bad;
        rst_n = 1'b0; in_R = 1'b0; m_ready = 1'b0; in_data = '0;
        #3;
        check("rst_out_A", out_A, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_level", level, 0);
        do_reset();

        m_ready = 1'b1;
        send(32'hA5A5_0001, 0);
        n = 0;
        do begin @(posedge clk); n++; #1; end while (!out_A && n < 20);
        check("ack_latency", n, SS + 1);
        @(posedge clk); #1;
        check("single_valid", m_valid, 1);
        check("single_data", m_data, 32'hA5A5_0001);
        repeat (2) @(posedge clk); #1;
        check("single_level", level, 0);
        check("single_valid_off", m_valid, 0);
        check("single_acks", tog, 1);

        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) send(i, 0);
        drain_check("stream", 8);
        check("stream_out_A", out_A, 0);

        do_reset();
        fork
            for (int i = 1; i <= 6; i++) send(i, 0);
            begin
                repeat (40) @(negedge clk);
                check("full_level", level, DEP);
                check("full_acks", tog, 4);
                check("full_state", 32'(dut.state), 32'(STALL));
                bad = 0;
                repeat (10) begin
                    @(negedge clk);
                    if (m_data !== 32'd1 || level !== DEP || m_valid !== 1'b1) bad++;
                end
                check("bp_stable", bad, 0);
                m_ready = 1'b1;
            end
        join
        drain_check("full", 6);

        do_reset();
        send(32'h11, 0);
        send(32'h22, 0);
        send(32'h33, 0);
        repeat (SS) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("pushpop_level", level, 2);
        drain_check("pushpop", 3);

        do_reset();
        sdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) send($urandom, $urandom_range(0, 3));
                sdone = 1'b1;
            end
            while (!sdone) begin @(negedge clk); m_ready = 1'($urandom_range(0, 1)); end
        join
        drain_check("rand", 24);

        do_reset();
        for (int i = 1; i <= 3; i++) send(32'h100 + i, 0);
        n = 0;
        while (in_R !== out_A && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_data = 32'h104;
        in_R = ~in_R;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_out_A", out_A, 0);
        check("mid_rst_level", level, 0);
        expq.delete();
        in_R = 1'b0;
        repeat (2) @(negedge clk);
        tog = 0; pops = 0;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_out_A", out_A, 0);
        check("post_rst_level", level, 0);
        check("post_rst_valid", m_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
